// File: rtl/cache_fill_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cache_fill_pkg
//  Description : Shared types and constants for the cache block-fill
//                controller: FSM state encoding, block geometry and the
//                block-align mask helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package cache_fill_pkg;

   // Default block geometry: 8 words of 16 bits (16-byte block).
   localparam int WORDS_PER_BLOCK = 8;
   localparam int WORD_IDX_W      = $clog2(WORDS_PER_BLOCK);
   // Byte-offset bits inside a block (word index plus the byte-in-word bit).
   localparam int BLOCK_OFFSET_W  = WORD_IDX_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_COMMIT = 2'd3
   } fill_state_t;

   // Mask that clears the low offset_w bits of an address.
   function automatic logic [31:0] block_align_mask(input int offset_w);
      return ~((32'd1 << offset_w) - 32'd1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/cache_fill_ctrl_fill_word_counter.sv
`default_nettype none
// ============================================================================
//  Module      : fill_word_counter
//  Description : Word-index counter for a block fill. Synchronous clear has
//                priority over enable; wraps naturally at 2^WIDTH.
//  Ports       : clk, rst_n (async active-low), clear, enable,
//                count    - current word index
//                terminal - count is at its last value (all ones)
//  Revision    : 1.0 - initial release
// ============================================================================
module fill_word_counter #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             enable,
   output logic [WIDTH-1:0] count,
   output logic             terminal
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

   assign terminal = &count;

endmodule
`default_nettype wire

// File: rtl/cache_fill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cache_fill_ctrl
//  Description : Cache block-fill initiator for a multi-cycle memory with
//                one-cycle writes and pipelined reads. On a miss it issues one
//                read per cycle for every word of the block, writes each
//                returning word into the data array (counted by
//                mem_data_valid, never by a timer), then writes the tag.
//                When idle it forwards single-word write-through stores.
//  Ports       : miss_detected/miss_address - fill request (sampled in IDLE)
//                wr_req/wr_addr/wr_data/wr_ack - write-through store channel
//                fsm_busy - fill in progress
//                fill_we/fill_word/fill_data - data-array write port
//                tag_we/fill_tag_addr - tag-array write port
//                mem_* - memory interface
//  Options     : `define CRIT_WORD_FIRST_EN to issue and fill starting at the
//                missing word (critical word first), wrapping in the block.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_fill_ctrl #(
   parameter int ADDR_WIDTH      = 16,
   parameter int WORDS_PER_BLOCK = cache_fill_pkg::WORDS_PER_BLOCK
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               miss_detected,
   input  logic [ADDR_WIDTH-1:0]              miss_address,
   input  logic                               wr_req,
   input  logic [ADDR_WIDTH-1:0]              wr_addr,
   input  logic [15:0]                        wr_data,
   output logic                               wr_ack,
   output logic                               fsm_busy,
   output logic                               fill_we,
   output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word,
   output logic [15:0]                        fill_data,
   output logic                               tag_we,
   output logic [ADDR_WIDTH-1:0]              fill_tag_addr,
   output logic                               mem_enable,
   output logic                               mem_wr,
   output logic [ADDR_WIDTH-1:0]              mem_addr,
   output logic [15:0]                        mem_data_out,
   input  logic [15:0]                        mem_data_in,
   input  logic                               mem_data_valid
);

   import cache_fill_pkg::*;

   localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
   localparam int OFF_W = IDX_W + 1;
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(block_align_mask(OFF_W));
   localparam logic [ADDR_WIDTH-1:0] HALF_MASK  = {{(ADDR_WIDTH-1){1'b1}}, 1'b0};

   fill_state_t           state;
   fill_state_t           state_nxt;
   logic [ADDR_WIDTH-1:0] base;
   logic [IDX_W-1:0]      start;
   logic [IDX_W-1:0]      issue_cnt;
   logic [IDX_W-1:0]      rcv_cnt;
   logic                  issue_last;
   logic                  rcv_last;
   logic                  accept_miss;
   logic                  receiving;
   logic [IDX_W-1:0]      issue_idx;
   logic [IDX_W-1:0]      rcv_idx;
   logic [ADDR_WIDTH-1:0] issue_offset;

   assign accept_miss  = (state == ST_IDLE) && miss_detected;
   // Valids outside ISSUE/DRAIN are stale (e.g. a fill aborted by reset).
   assign receiving    = ((state == ST_ISSUE) || (state == ST_DRAIN)) && mem_data_valid;
   assign issue_idx    = start + issue_cnt;
   assign rcv_idx      = start + rcv_cnt;
   assign issue_offset = {{(ADDR_WIDTH-OFF_W){1'b0}}, issue_idx, 1'b0};

   fill_word_counter #(.WIDTH(IDX_W)) u_issue_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (accept_miss),
      .enable   (state == ST_ISSUE),
      .count    (issue_cnt),
      .terminal (issue_last)
   );

   fill_word_counter #(.WIDTH(IDX_W)) u_rcv_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (accept_miss),
      .enable   (receiving),
      .count    (rcv_cnt),
      .terminal (rcv_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         base  <= '0;
      end else begin
         state <= state_nxt;
         if (accept_miss) begin
            base <= miss_address & ALIGN_MASK;
         end
      end
   end

`ifdef CRIT_WORD_FIRST_EN
   // Word offset of the missing access: issue and fill rotate from here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start <= '0;
      end else if (accept_miss) begin
         start <= miss_address[IDX_W:1];
      end
   end
`else
   assign start = '0;
`endif

   assign fill_data     = mem_data_in;
   assign fill_tag_addr = base;

   always_comb begin
      state_nxt    = state;
      wr_ack       = 1'b0;
      fsm_busy     = 1'b0;
      fill_we      = receiving;
      fill_word    = receiving ? rcv_idx : '0;
      tag_we       = 1'b0;
      mem_enable   = 1'b0;
      mem_wr       = 1'b0;
      mem_addr     = '0;
      mem_data_out = '0;

      case (state)
         ST_IDLE: begin
            if (miss_detected) begin
               state_nxt = ST_ISSUE;
            end else if (wr_req) begin
               mem_enable   = 1'b1;
               mem_wr       = 1'b1;
               mem_addr     = wr_addr & HALF_MASK;
               mem_data_out = wr_data;
               wr_ack       = 1'b1;
            end
         end
         ST_ISSUE: begin
            fsm_busy   = 1'b1;
            mem_enable = 1'b1;
            mem_addr   = base + issue_offset;
            if (issue_last) begin
               // A zero-latency memory could complete the block here.
               state_nxt = (receiving && rcv_last) ? ST_COMMIT : ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            fsm_busy = 1'b1;
            if (receiving && rcv_last) begin
               state_nxt = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            fsm_busy  = 1'b1;
            tag_we    = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_cache_fill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_fill_ctrl
//  Description : Directed self-checking bench for cache_fill_ctrl with a
//                pipelined in-order memory model (fixed 4-cycle latency or an
//                irregular 4/5/9-cycle pattern). Read data = address ^ 0x5A5A.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_fill_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        miss_detected = 1'b0;
   logic [15:0] miss_address = 16'h0;
   logic        wr_req = 1'b0;
   logic [15:0] wr_addr = 16'h0;
   logic [15:0] wr_data = 16'h0;
   logic        wr_ack;
   logic        fsm_busy;
   logic        fill_we;
   logic [2:0]  fill_word;
   logic [15:0] fill_data;
   logic        tag_we;
   logic [15:0] fill_tag_addr;
   logic        mem_enable;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_data_out;
   logic [15:0] mem_data_in = 16'h0;
   logic        mem_data_valid = 1'b0;

   int checks = 0;
   int errors = 0;

   cache_fill_ctrl #(.ADDR_WIDTH(16), .WORDS_PER_BLOCK(8)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .miss_detected  (miss_detected),
      .miss_address   (miss_address),
      .wr_req         (wr_req),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .wr_ack         (wr_ack),
      .fsm_busy       (fsm_busy),
      .fill_we        (fill_we),
      .fill_word      (fill_word),
      .fill_data      (fill_data),
      .tag_we         (tag_we),
      .fill_tag_addr  (fill_tag_addr),
      .mem_enable     (mem_enable),
      .mem_wr         (mem_wr),
      .mem_addr       (mem_addr),
      .mem_data_out   (mem_data_out),
      .mem_data_in    (mem_data_in),
      .mem_data_valid (mem_data_valid)
   );

   always #5 clk = ~clk;

   // ---------------- memory model ----------------
   int cyc = 0;
   int lat_mode = 0;
   int rd_seq = 0;
   int last_due = -1;
   int lat;
   int due;
   int lat_tab [3] = '{4, 5, 9};
   bit          pv [0:127];
   logic [15:0] pd [0:127];

   function automatic logic [15:0] mdata(input logic [15:0] a);
      return a ^ 16'h5A5A;
   endfunction

   function automatic int exp_start(input logic [15:0] a);
`ifdef CRIT_WORD_FIRST_EN
      return int'((a >> 1) & 16'h7);
`else
      return (a == 16'hFFFF) ? 0 : 0;
`endif
   endfunction

   always @(posedge clk) begin
      if (mem_enable === 1'b1 && mem_wr === 1'b0) begin
         lat = (lat_mode == 0) ? 4 : lat_tab[rd_seq % 3];
         due = cyc + lat;
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         pv[due % 128] = 1'b1;
         pd[due % 128] = mdata(mem_addr);
         rd_seq++;
      end
      cyc++;
      #1;
      mem_data_valid = pv[cyc % 128];
      mem_data_in    = pv[cyc % 128] ? pd[cyc % 128] : 16'h0000;
      pv[cyc % 128]  = 1'b0;
   end

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if ({fsm_busy, mem_enable, mem_wr, wr_ack, fill_we, tag_we} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl got %b want 000000",
                  {fsm_busy, mem_enable, mem_wr, wr_ack, fill_we, tag_we});
      end
      checks++;
      if (fill_tag_addr !== 16'h0 || mem_addr !== 16'h0 || fill_word !== 3'd0) begin
         errors++;
         $display("FAIL reset_addr tag=%h mem=%h word=%0d want 0", fill_tag_addr, mem_addr, fill_word);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic_fill();
      int st;
      logic [15:0] ea;
      logic [2:0]  ew;
      st = exp_start(16'h1234);
      @(posedge clk); #2;
      miss_detected = 1'b1;
      miss_address  = 16'h1234;
      checks++;
      if (mem_enable !== 1'b0 || fsm_busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_c0 en=%b busy=%b want 0 0", mem_enable, fsm_busy);
      end
      for (int k = 1; k <= 14; k++) begin
         @(posedge clk); #2;
         if (k == 1) miss_detected = 1'b0;
         checks++;
         if (fsm_busy !== (k <= 13)) begin
            errors++;
            $display("FAIL basic_busy cyc%0d got %b want %b", k, fsm_busy, (k <= 13));
         end
         if (k <= 8) begin
            ea = 16'h1230 + 16'(2 * ((st + k - 1) % 8));
            checks++;
            if (mem_enable !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== ea) begin
               errors++;
               $display("FAIL basic_issue cyc%0d en=%b wr=%b addr=%h want 1 0 %h", k, mem_enable, mem_wr, mem_addr, ea);
            end
         end else begin
            checks++;
            if (mem_enable !== 1'b0) begin
               errors++;
               $display("FAIL basic_noissue cyc%0d en=%b want 0", k, mem_enable);
            end
         end
         if (k >= 5 && k <= 12) begin
            ew = 3'((st + k - 5) % 8);
            ea = 16'h1230 + {12'd0, ew, 1'b0};
            checks++;
            if (fill_we !== 1'b1 || fill_word !== ew || fill_data !== mdata(ea)) begin
               errors++;
               $display("FAIL basic_fill cyc%0d we=%b word=%0d data=%h want 1 %0d %h", k, fill_we, fill_word, fill_data, ew, mdata(ea));
            end
         end else begin
            checks++;
            if (fill_we !== 1'b0) begin
               errors++;
               $display("FAIL basic_nofill cyc%0d we=%b want 0", k, fill_we);
            end
         end
         checks++;
         if (tag_we !== (k == 13) || (k == 13 && fill_tag_addr !== 16'h1230)) begin
            errors++;
            $display("FAIL basic_tag cyc%0d we=%b addr=%h want %b 1230", k, tag_we, fill_tag_addr, (k == 13));
         end
      end
   endtask

   task automatic test_store_during_fill();
      @(posedge clk); #2;
      miss_detected = 1'b1;
      miss_address  = 16'h1234;
      wr_req  = 1'b1;
      wr_addr = 16'h0041;
      wr_data = 16'hBEEF;
      checks++;
      if (wr_ack !== 1'b0 || mem_enable !== 1'b0) begin
         errors++;
         $display("FAIL store_prio ack=%b en=%b want 0 0", wr_ack, mem_enable);
      end
      for (int k = 1; k <= 14; k++) begin
         @(posedge clk); #2;
         if (k == 1) miss_detected = 1'b0;
         if (k <= 13) begin
            checks++;
            if (wr_ack !== 1'b0 || mem_wr !== 1'b0) begin
               errors++;
               $display("FAIL store_blocked cyc%0d ack=%b wr=%b want 0 0", k, wr_ack, mem_wr);
            end
         end else begin
            checks++;
            if (wr_ack !== 1'b1 || mem_enable !== 1'b1 || mem_wr !== 1'b1 ||
                mem_addr !== 16'h0040 || mem_data_out !== 16'hBEEF || fsm_busy !== 1'b0) begin
               errors++;
               $display("FAIL store_issue ack=%b en=%b wr=%b addr=%h data=%h busy=%b want 1 1 1 0040 beef 0",
                        wr_ack, mem_enable, mem_wr, mem_addr, mem_data_out, fsm_busy);
            end
         end
      end
      wr_req = 1'b0;
      #1;
      checks++;
      if (wr_ack !== 1'b0 || mem_enable !== 1'b0) begin
         errors++;
         $display("FAIL store_release ack=%b en=%b want 0 0", wr_ack, mem_enable);
      end
   endtask

   task automatic test_reset_mid_fill();
      @(posedge clk); #2;
      miss_detected = 1'b1;
      miss_address  = 16'h1234;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #2;
         if (k == 1) miss_detected = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({fsm_busy, mem_enable, fill_we, tag_we} !== 4'b0 || fill_tag_addr !== 16'h0) begin
         errors++;
         $display("FAIL rst_async busy=%b en=%b fwe=%b twe=%b tag=%h want 0 0 0 0 0000",
                  fsm_busy, mem_enable, fill_we, tag_we, fill_tag_addr);
      end
      for (int k = 7; k <= 14; k++) begin
         @(posedge clk); #2;
         if (k == 7) rst_n = 1'b1;
         checks++;
         if (fill_we !== 1'b0 || tag_we !== 1'b0 || fsm_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_stale cyc%0d fwe=%b twe=%b busy=%b valid=%b want 0 0 0", k, fill_we, tag_we, fsm_busy, mem_data_valid);
         end
      end
      repeat (6) @(posedge clk);
   endtask

   task automatic run_fill(input string name, input logic [15:0] addr, input int mode);
      logic [15:0] base;
      logic [15:0] ea;
      logic [2:0]  w;
      int st, ni, nr;
      bit done;
      base = addr & 16'hFFF0;
      st   = exp_start(addr);
      ni = 0; nr = 0; done = 1'b0;
      lat_mode = mode;
      @(posedge clk); #2;
      miss_detected = 1'b1;
      miss_address  = addr;
      @(posedge clk); #2;
      miss_detected = 1'b0;
      for (int k = 0; k < 60 && !done; k++) begin
         if (mem_enable === 1'b1) begin
            w  = 3'((st + ni) % 8);
            ea = base + {12'd0, w, 1'b0};
            checks++;
            if (mem_wr !== 1'b0 || mem_addr !== ea || ni >= 8) begin
               errors++;
               $display("FAIL %s_issue n=%0d wr=%b addr=%h want 0 %h", name, ni, mem_wr, mem_addr, ea);
            end
            ni++;
         end
         if (fill_we === 1'b1) begin
            w  = 3'((st + nr) % 8);
            ea = base + {12'd0, w, 1'b0};
            checks++;
            if (fill_word !== w || fill_data !== mdata(ea) || nr >= 8) begin
               errors++;
               $display("FAIL %s_fill n=%0d word=%0d data=%h want %0d %h", name, nr, fill_word, fill_data, w, mdata(ea));
            end
            nr++;
         end
         if (tag_we === 1'b1) begin
            checks++;
            if (nr != 8 || ni != 8 || fill_tag_addr !== base) begin
               errors++;
               $display("FAIL %s_tag recv=%0d issued=%0d addr=%h want 8 8 %h", name, nr, ni, fill_tag_addr, base);
            end
            done = 1'b1;
         end
         if (!done) begin
            @(posedge clk); #2;
         end
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s_timeout tag_we=0 after 60 cycles recv=%0d want tag_we", name, nr);
      end
      @(posedge clk); #2;
      checks++;
      if (fsm_busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_idle busy=%b want 0", name, fsm_busy);
      end
      lat_mode = 0;
   endtask

   task automatic test_irregular_latency();
      run_fill("irregular", 16'h1234, 1);
   endtask

   task automatic test_crit_word();
      run_fill("critword", 16'h200A, 0);
   endtask

   task automatic test_top_of_space();
      run_fill("topaddr", 16'hFFFE, 0);
   endtask

   initial begin
      test_reset();
      test_basic_fill();
      test_store_during_fill();
      test_reset_mid_fill();
      test_irregular_latency();
      test_crit_word();
      test_top_of_space();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
